// File: rtl/serial_pkg.sv
// Shared definitions for the serial baud-rate generator: mode encodings,
// prescaler divisors, sample window and phase counter width.
package serial_pkg;

  typedef enum logic [1:0] {
    SER_MODE0 = 2'b00,
    SER_MODE1 = 2'b01,
    SER_MODE2 = 2'b10,
    SER_MODE3 = 2'b11
  } ser_mode_e;

  localparam int PHASE_W         = 4;
  localparam int DIV_MODE0       = 12;
  localparam int DIV_MODE2_SMOD0 = 4;
  localparam int DIV_MODE2_SMOD1 = 2;
  localparam int SAMPLE_PH_LO    = 7;
  localparam int SAMPLE_PH_HI    = 9;

  typedef logic [PHASE_W-1:0] phase_t;

  // True for the three receive phases used by the majority-vote sampler.
  function automatic logic inSampleWindow(input phase_t ph);
    return (ph >= phase_t'(SAMPLE_PH_LO)) && (ph <= phase_t'(SAMPLE_PH_HI));
  endfunction

endpackage

// File: rtl/serial_brg_if.sv
// Mode/strobe inputs and tick outputs of the baud-rate generator,
// bundled so the generator and its driver share one connection.
interface serial_brg_if;

  logic                  serial_scon7_sm0_i;
  logic                  serial_scon6_sm1_i;
  logic                  serial_pcon7_smod_i;
  logic                  serial_timer1_ovf_i;
  logic                  serial_clear_count_i;
  logic                  serial_br_o;
  logic                  serial_br_trans_o;
  logic                  serial_sample_o;
  serial_pkg::phase_t    serial_rx_phase_o;

  modport master (
    output serial_scon7_sm0_i,
    output serial_scon6_sm1_i,
    output serial_pcon7_smod_i,
    output serial_timer1_ovf_i,
    output serial_clear_count_i,
    input  serial_br_o,
    input  serial_br_trans_o,
    input  serial_sample_o,
    input  serial_rx_phase_o
  );

  modport slave (
    input  serial_scon7_sm0_i,
    input  serial_scon6_sm1_i,
    input  serial_pcon7_smod_i,
    input  serial_timer1_ovf_i,
    input  serial_clear_count_i,
    output serial_br_o,
    output serial_br_trans_o,
    output serial_sample_o,
    output serial_rx_phase_o
  );

endinterface

// File: rtl/serial_phase_cnt.sv
// Free-running 16-phase counter advanced by receive ticks; clear wins over
// tick, and o_wrap flags the tick that carries the count from 15 back to 0.
module serial_phase_cnt
  import serial_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_b,
  input  logic   i_tick,
  input  logic   i_clear,
  output phase_t o_count,
  output logic   o_wrap
);

  phase_t r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_tick) begin
      r_count <= r_count + phase_t'(1);
    end
  end

  assign o_count = r_count;
  assign o_wrap  = i_tick && !i_clear && (r_count == '1);

endmodule

// File: rtl/serial_brg.sv
// 8051-style serial baud-rate generator: derives receive, transmit and
// sample strobes from fosc or Timer1 overflows according to SM0/SM1/SMOD.
module serial_brg
  import serial_pkg::*;
#(
  parameter int MODE0_DIV = DIV_MODE0
) (
  input  logic         serial_clock_i,
  input  logic         serial_reset_i_b,
  serial_brg_if.slave  bus
);

  ser_mode_e  w_mode;
  logic [2:0] w_cfg;
  logic [2:0] r_cfg;
  logic       w_cfgChange;
  logic       w_mode0;
  logic [3:0] w_div;
  logic       w_presRun;
  logic       w_presWrap;
  logic       w_srcTick;
  logic       w_tick;
  logic       w_rxClear;
  logic       w_txClear;
  logic       w_txWrap;
  logic       w_unusedRxWrap;
  phase_t     w_rxPhase;
  phase_t     w_txPhase;
  logic [3:0] r_pres;
  logic       r_t1Toggle;
  logic       r_br;
  logic       r_brTrans;
  logic       r_sample;

  assign w_mode      = ser_mode_e'({bus.serial_scon7_sm0_i, bus.serial_scon6_sm1_i});
  assign w_cfg       = {bus.serial_scon7_sm0_i, bus.serial_scon6_sm1_i, bus.serial_pcon7_smod_i};
  assign w_cfgChange = (w_cfg != r_cfg);
  assign w_mode0     = (w_mode == SER_MODE0);

  always_comb begin
    w_div     = 4'(MODE0_DIV);
    w_presRun = 1'b0;
    case (w_mode)
      SER_MODE0: begin
        w_div     = 4'(MODE0_DIV);
        w_presRun = 1'b1;
      end
      SER_MODE2: begin
        w_div     = bus.serial_pcon7_smod_i ? 4'(DIV_MODE2_SMOD1) : 4'(DIV_MODE2_SMOD0);
        w_presRun = 1'b1;
      end
      default: begin
        w_div     = 4'(MODE0_DIV);
        w_presRun = 1'b0;
      end
    endcase
  end

  // Modes 1/3 take their tick from Timer1; without SMOD only every second overflow counts.
  assign w_presWrap = w_presRun && (r_pres == (w_div - 4'd1));
  assign w_srcTick  = w_presRun ? w_presWrap
                                : (bus.serial_timer1_ovf_i && (bus.serial_pcon7_smod_i || r_t1Toggle));
  assign w_tick     = w_srcTick && !w_cfgChange;
  assign w_rxClear  = w_cfgChange || w_mode0 || bus.serial_clear_count_i;
  assign w_txClear  = w_cfgChange || w_mode0;

  always_ff @(posedge serial_clock_i) begin
    if (!serial_reset_i_b) begin
      r_cfg      <= '0;
      r_pres     <= '0;
      r_t1Toggle <= 1'b0;
    end else begin
      r_cfg <= w_cfg;
      if (w_cfgChange || !w_presRun || w_presWrap) begin
        r_pres <= '0;
      end else begin
        r_pres <= r_pres + 4'd1;
      end
      if (w_cfgChange) begin
        r_t1Toggle <= 1'b0;
      end else if (!w_presRun && !bus.serial_pcon7_smod_i && bus.serial_timer1_ovf_i) begin
        r_t1Toggle <= ~r_t1Toggle;
      end
    end
  end

  serial_phase_cnt u_rxPhase (
    .i_clk   (serial_clock_i),
    .i_rst_b (serial_reset_i_b),
    .i_tick  (w_tick),
    .i_clear (w_rxClear),
    .o_count (w_rxPhase),
    .o_wrap  (w_unusedRxWrap)
  );

  serial_phase_cnt u_txPhase (
    .i_clk   (serial_clock_i),
    .i_rst_b (serial_reset_i_b),
    .i_tick  (w_tick),
    .i_clear (w_txClear),
    .o_count (w_txPhase),
    .o_wrap  (w_txWrap)
  );

  // A resync landing on a tick still emits the tick but must not vote a sample.
  always_ff @(posedge serial_clock_i) begin
    if (!serial_reset_i_b) begin
      r_br      <= 1'b0;
      r_brTrans <= 1'b0;
      r_sample  <= 1'b0;
    end else begin
      r_br <= w_tick;
      if (w_mode0) begin
        r_brTrans <= w_tick;
        r_sample  <= w_tick;
      end else begin
        r_brTrans <= w_txWrap;
        r_sample  <= w_tick && !bus.serial_clear_count_i && inSampleWindow(w_rxPhase);
      end
    end
  end

  assign bus.serial_br_o       = r_br;
  assign bus.serial_br_trans_o = r_brTrans;
  assign bus.serial_sample_o   = r_sample;
  assign bus.serial_rx_phase_o = w_rxPhase;

endmodule

// File: tb/tb_serial_brg.sv
// Self-checking bench for serial_brg: period table per mode, hand-written
// corner sequences, and randomized traffic against a counting reference model.
module tb_serial_brg;

  localparam int MODE0_DIV_TB = 12;

  logic clk = 1'b0;
  logic rstb;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: counts clocks, overflows and ticks since the last epoch.
  int         mClk, mOvf, mTick, mRxStart;
  logic [2:0] mCfg;
  logic       eBr, eTrans, eSample;
  logic [3:0] ePhase;

  typedef struct {
    string name;
    logic  sm0;
    logic  sm1;
    logic  smod;
    int    ovfPeriod;
    int    brGap;
    int    transGap;
    int    samplesPerBit;
  } periodVec_t;

  periodVec_t vecs [7];

  serial_brg_if bus ();

  serial_brg #(.MODE0_DIV(MODE0_DIV_TB)) dut (
    .serial_clock_i   (clk),
    .serial_reset_i_b (rstb),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void modelZero();
    mClk = 0; mOvf = 0; mTick = 0; mRxStart = 0;
    eBr = 1'b0; eTrans = 1'b0; eSample = 1'b0; ePhase = 4'd0;
  endfunction

  function automatic void modelEdge(input logic rb, input logic [2:0] cfg,
                                    input logic ovf, input logic clr);
    int n;
    int phBefore;
    bit tick;
    if (!rb) begin
      modelZero();
      mCfg = 3'b000;
      return;
    end
    if (cfg != mCfg) begin
      modelZero();
      mCfg = cfg;
      return;
    end
    tick = 1'b0;
    case (cfg[2:1])
      2'b00:   n = MODE0_DIV_TB;
      2'b10:   n = cfg[0] ? 2 : 4;
      default: n = 0;
    endcase
    if (n > 0) begin
      mClk++;
      tick = (mClk % n == 0);
    end else if (ovf) begin
      mOvf++;
      tick = cfg[0] || (mOvf % 2 == 0);
    end
    if (cfg[2:1] == 2'b00) begin
      eBr = tick; eTrans = tick; eSample = tick; ePhase = 4'd0;
    end else begin
      phBefore = (mTick - mRxStart) % 16;
      if (tick) mTick++;
      if (clr) mRxStart = mTick;
      eBr     = tick;
      eTrans  = tick && (mTick % 16 == 0);
      eSample = tick && !clr && (phBefore >= 7) && (phBefore <= 9);
      ePhase  = 4'((mTick - mRxStart) % 16);
    end
  endfunction

  task automatic applyStimulus(input logic rb, input logic sm0, input logic sm1,
                               input logic smod, input logic ovf, input logic clr);
    rstb                     = rb;
    bus.serial_scon7_sm0_i   = sm0;
    bus.serial_scon6_sm1_i   = sm1;
    bus.serial_pcon7_smod_i  = smod;
    bus.serial_timer1_ovf_i  = ovf;
    bus.serial_clear_count_i = clr;
    @(posedge clk);
    cyc++;
    modelEdge(rb, {sm0, sm1, smod}, ovf, clr);
    @(negedge clk);
  endtask

  function automatic logic [6:0] dutOut();
    return {bus.serial_br_o, bus.serial_br_trans_o, bus.serial_sample_o, bus.serial_rx_phase_o};
  endfunction

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name);
    checkVal(name, int'(dutOut()), int'({eBr, eTrans, eSample, ePhase}));
  endtask

  task automatic resetDut(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    int   first, pulses, lastBr, lastTr, badBr, badTr, badS, badEq, badPh, trCnt, sSince, tPrev;
    int   found;
    logic ovf;
    logic [2:0] rCfg;

    mCfg = 3'b000;
    modelZero();

    vecs[0] = '{"mode0",            1'b0, 1'b0, 1'b0, 0, 12,  12, 1};
    vecs[1] = '{"mode2 smod0 ovf3", 1'b1, 1'b0, 1'b0, 3,  4,  64, 3};
    vecs[2] = '{"mode2 smod1",      1'b1, 1'b0, 1'b1, 0,  2,  32, 3};
    vecs[3] = '{"mode1 smod0",      1'b0, 1'b1, 1'b0, 5, 10, 160, 3};
    vecs[4] = '{"mode1 smod1",      1'b0, 1'b1, 1'b1, 5,  5,  80, 3};
    vecs[5] = '{"mode3 smod0",      1'b1, 1'b1, 1'b0, 5, 10, 160, 3};
    vecs[6] = '{"mode0 smod1 ovf2", 1'b0, 0,    1'b1, 2, 12,  12, 1};

    // Reset state
    for (int i = 0; i < 3; i++) begin
      resetDut(1);
      checkVal("reset outputs", int'(dutOut()), 0);
    end

    // Mode 0 for 60 clocks after reset
    pulses = 0; lastBr = -1; badBr = 0; badEq = 0; badPh = 0; first = -1;
    for (int c = 1; c <= 60; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.serial_br_o) begin
        if (first < 0) first = c;
        if (lastBr >= 0 && c - lastBr != 12) badBr++;
        lastBr = c;
        pulses++;
      end
      if (bus.serial_br_o != bus.serial_br_trans_o || bus.serial_br_o != bus.serial_sample_o) badEq++;
      if (bus.serial_rx_phase_o != 4'd0) badPh++;
    end
    checkVal("mode0 pulse count", pulses, 5);
    checkVal("mode0 first tick", first, 12);
    checkVal("mode0 bad gaps", badBr, 0);
    checkVal("mode0 strobes unequal", badEq, 0);
    checkVal("mode0 nonzero phase", badPh, 0);

    // Mode 2 SMOD=0 first tick after reset release
    resetDut(2);
    first = -1;
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.serial_br_o && first < 0) first = c;
    end
    checkVal("mode2 first tick after reset", first, 5);
    checkOutput("mode2 model after reset");

    // Clear at rx phase 11 leaves tx wrap timing alone
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      found = int'(bus.serial_br_trans_o);
    end
    checkVal("reach tx wrap", found, 1);
    tPrev = cyc;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      found = int'(bus.serial_rx_phase_o == 4'd11);
    end
    checkVal("reach rx phase 11", found, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("clear at phase 11", int'(bus.serial_rx_phase_o), 0);
    checkOutput("clear at phase 11 model");
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      found = int'(bus.serial_br_trans_o);
    end
    checkVal("tx wrap spacing across clear", found != 0 ? cyc - tPrev : -1, 64);

    // Clear coincident with a tick whose pre-phase is 7
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      found = int'(bus.serial_br_o && bus.serial_rx_phase_o == 4'd7);
    end
    checkVal("reach tick at phase 7", found, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("clear+tick br", int'(bus.serial_br_o), 1);
    checkVal("clear+tick sample", int'(bus.serial_sample_o), 0);
    checkVal("clear+tick phase", int'(bus.serial_rx_phase_o), 0);

    // Mode 2 -> 0 switch at rx phase 5
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      found = int'(bus.serial_rx_phase_o == 4'd5);
    end
    checkVal("reach rx phase 5", found, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("mode switch idle cycle", int'(dutOut()), 0);
    first = -1;
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.serial_br_o && first < 0) first = c;
    end
    checkVal("mode0 first tick after switch", first, 12);

    // Reset mid-bit, then restart from count 0
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("reset mid-bit", int'(dutOut()), 0);
    first = -1;
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.serial_br_o && first < 0) first = c;
    end
    checkVal("first tick after mid reset", first, 5);

    // Period table
    foreach (vecs[k]) begin
      resetDut(2);
      lastBr = -1; lastTr = -1; badBr = 0; badTr = 0; badS = 0; trCnt = 0; sSince = 0;
      for (int c = 0; c < 420; c++) begin
        if (vecs[k].ovfPeriod > 0) ovf = (c % vecs[k].ovfPeriod == vecs[k].ovfPeriod - 1);
        else ovf = 1'b0;
        applyStimulus(1'b1, vecs[k].sm0, vecs[k].sm1, vecs[k].smod, ovf, 1'b0);
        if (bus.serial_sample_o) sSince++;
        if (bus.serial_br_o) begin
          if (lastBr >= 0 && c - lastBr != vecs[k].brGap) badBr++;
          lastBr = c;
        end
        if (bus.serial_br_trans_o) begin
          if (lastTr >= 0) begin
            if (c - lastTr != vecs[k].transGap) badTr++;
            if (sSince != vecs[k].samplesPerBit) badS++;
          end
          lastTr = c;
          trCnt++;
          sSince = 0;
        end
      end
      checkVal($sformatf("%s br gap errors", vecs[k].name), badBr, 0);
      checkVal($sformatf("%s trans gap errors", vecs[k].name), badTr, 0);
      checkVal($sformatf("%s samples per bit errors", vecs[k].name), badS, 0);
      checkVal($sformatf("%s two trans pulses seen", vecs[k].name), int'(trCnt >= 2), 1);
    end

    // Randomized traffic against the reference model
    resetDut(2);
    rCfg = 3'($urandom_range(0, 7));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) rCfg = 3'($urandom_range(0, 7));
      applyStimulus(1'($urandom_range(0, 499) != 0), rCfg[2], rCfg[1], rCfg[0],
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) == 0));
      checkOutput($sformatf("random cycle %0d cfg %0b", i, rCfg));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_brg.md
SERIAL_BRG -- requirements
Module: serial_brg

Interface
REQ-001 Parameter: MODE0_DIV, 12, clocks per mode-0 shift tick (fosc/12).
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 serial_clock_i  in  1  system clock; all state updates on its rising edge.
REQ-004 serial_reset_i_b  in  1  synchronous active-low reset.
REQ-005 serial_scon7_sm0_i  in  1  SCON.SM0 mode bit.
REQ-006 serial_scon6_sm1_i  in  1  SCON.SM1 mode bit.
REQ-007 serial_pcon7_smod_i  in  1  PCON.SMOD baud doubler.
REQ-008 serial_timer1_ovf_i  in  1  one-cycle Timer1 overflow strobe.
REQ-009 serial_clear_count_i  in  1  receiver start-bit resync request, one cycle.
REQ-010 serial_br_o  out  1  one-cycle receive tick (16x bit rate; 1x in mode 0), feeds serial_rx serial_br_i.
REQ-011 serial_br_trans_o  out  1  one-cycle transmit bit tick, feeds serial_rx/serial_tx serial_br_trans_i.
REQ-012 serial_sample_o  out  1  one-cycle majority-vote sample strobe, at receive phases 7, 8, 9.
REQ-013 serial_rx_phase_o  out  4  current receive phase, 0..15.

Function
REQ-014 Mode from {SM0,SM1}: 00 mode 0, 01 mode 1, 10 mode 2, 11 mode 3.
REQ-015 Every output is registered; every tick lasts exactly one clock.
REQ-016 Prescaler, 4 bits: counts 0..N-1 and wraps; a tick is generated on the N-1 -> 0 edge.
REQ-017 Mode 0: N=MODE0_DIV.
- Each tick pulses serial_br_o, serial_br_trans_o and serial_sample_o together.
- Both phase counters are held at 0.
REQ-018 Mode 2: N=4 when SMOD=0, N=2 when SMOD=1; each prescaler tick is a receive tick.
REQ-019 Modes 1/3: prescaler is idle at 0.
- SMOD=1: each serial_timer1_ovf_i is a receive tick.
- SMOD=0: a T1 toggle flop divides by 2; every second overflow is a receive tick.
REQ-020 Receive tick latency: serial_br_o is high in the clock after the edge that detects the tick source.
REQ-021 Receive phase counter: 4 bits, increments on each receive tick, wraps 15 -> 0.
REQ-022 serial_sample_o pulses with serial_br_o when the receive phase before the increment is 7, 8 or 9.
REQ-023 Transmit phase counter: 4 bits, increments on each receive tick; serial_br_trans_o pulses with the tick on the 15 -> 0 wrap.
REQ-024 The transmit phase counter is never affected by serial_clear_count_i.
REQ-025 serial_clear_count_i zeroes the receive phase counter on the next edge; prescaler and T1 toggle are unaffected.
REQ-026 Clear coincident with a receive tick: the counter loads 0, serial_br_o still pulses, and serial_sample_o is suppressed.
REQ-027 Mode/SMOD change: a registered copy of {SM0,SM1,SMOD} is compared each clock.
- On mismatch, prescaler, T1 toggle and both phase counters load 0 on the next edge.
- No tick is emitted in that cycle.
REQ-028 serial_timer1_ovf_i is ignored in modes 0 and 2.

Reset
REQ-029 While serial_reset_i_b=0 at a rising edge, all outputs and the internal counters, T1 toggle and mode copy load 0.
REQ-030 Reset is applied mid-operation without residue; the first tick after release follows REQ-016 to REQ-019 from count 0.
REQ-031 Mode 2, SMOD=0: first serial_br_o is 4 edges after the first edge with reset deasserted.

Structure
REQ-032 Shared package serial_pkg holds:
- mode encodings SER_MODE0..SER_MODE3;
- divisor constants DIV_MODE0=12, DIV_MODE2_SMOD0=4, DIV_MODE2_SMOD1=2;
- SAMPLE_PH_LO=7, SAMPLE_PH_HI=9;
- phase width 4.
REQ-033 One sub-module, serial_phase_cnt: a 4-bit counter with tick, clear and wrap-pulse; it is instantiated twice, for rx and tx.

Verification
REQ-034 Mode 0, 60 clocks after reset: serial_br_o = serial_br_trans_o = serial_sample_o, with 5 pulses spaced 12 clocks; serial_rx_phase_o=0.
REQ-035 Mode 2, SMOD=0: serial_br_o every 4 clocks; serial_br_trans_o every 64 clocks; serial_sample_o 3 consecutive ticks per bit, at phases 7, 8, 9.
REQ-036 Mode 2, SMOD=1: serial_br_o every 2 clocks; serial_br_trans_o every 32 clocks.
REQ-037 Mode 1, overflow every 5 clocks:
- SMOD=0 gives serial_br_o every 10 clocks;
- SMOD=1 gives every 5 clocks;
- serial_br_trans_o every 16 serial_br_o.
REQ-038 Mode 2: pulse serial_clear_count_i at rx phase 11.
- Next serial_rx_phase_o=0, and the tx wrap timing is unchanged.
- Clear coincident with a tick: serial_br_o=1 and serial_sample_o=0.
REQ-039 Mid-operation events:
- Switch mode 2 -> 0 at rx phase 5: one idle cycle, then the first mode-0 tick 12 clocks later.
- Assert reset mid-bit: all outputs 0 on the next edge.
